fetch_queue: RTL and testbench

- Instruction fetch stage directly upstream of the opcode decoder.
- Reads the instruction stream one byte at a time from a byte-wide instruction memory into a small prefetch queue.
- Presents the 4 bytes at the current instruction pointer as ope[31:0], with the first byte in ope[31:24].
- Retires bytes when the decoder-side control reports the instruction length (num_of_ope). Restarts from a new address on call/ret/jump redirect.

---
 rtl/fetch_queue.sv | 160 ++++++++++++++++
 tb/tb_fetch_queue.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// Byte-wide instruction prefetch queue feeding the opcode decoder.
// Streams bytes from instruction memory into a circular buffer and presents the 4 head bytes.
module fetch_queue #(
  parameter int unsigned QDEPTH     = 8,
  parameter logic [31:0] RESET_ADDR = 32'h0000_0000
) (
  input  logic        clk2,
  input  logic        reset,
  input  logic        redirect,
  input  logic [31:0] redirect_addr,
  input  logic        adv,
  input  logic [3:0]  adv_len,
  output logic [31:0] ope,
  output logic        ope_valid,
  output logic [31:0] head_addr,
  output logic [3:0]  count,
  output logic        err_len,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [7:0]  mem_data
);
  localparam int unsigned   PW  = $clog2(QDEPTH);
  localparam logic [3:0]    QD4 = 4'(QDEPTH);
  localparam logic [PW+3:0] QDW = (PW+4)'(QDEPTH);

  typedef enum logic [1:0] {StIdle, StBusy, StDiscard} state_e;

  state_e        state_q, state_d;
  logic [PW-1:0] head_q, head_d, tail_q, tail_d;
  logic [3:0]    count_q, count_d;
  logic [31:0]   head_addr_q, head_addr_d;
  logic [31:0]   fetch_q, fetch_d;
  logic [31:0]   mem_addr_q, mem_addr_d;
  logic          mem_req_q, mem_req_d;
  logic          err_len_q, err_len_d;
  logic [7:0]    buf_q [QDEPTH];
  logic          push, adv_ok;
  logic [3:0]    retire, cnt_nxt;

  // Pointer add modulo QDEPTH; n never exceeds QDEPTH so one correction suffices.
  function automatic logic [PW-1:0] wrap_add(input logic [PW-1:0] p, input logic [3:0] n);
    logic [PW+3:0] s;
    s = {4'b0000, p} + {{PW{1'b0}}, n};
    if (s >= QDW) s = s - QDW;
    return s[PW-1:0];
  endfunction

  always_comb begin
    adv_ok  = adv && (adv_len != 4'd0) && (adv_len <= 4'd6) && (adv_len <= count_q);
    push    = (state_q == StBusy) && mem_ack && !redirect;
    retire  = adv_ok ? adv_len : 4'd0;
    cnt_nxt = count_q + {3'b000, push} - retire;

    state_d     = state_q;
    head_d      = head_q;
    tail_d      = tail_q;
    count_d     = count_q;
    head_addr_d = head_addr_q;
    fetch_d     = fetch_q;
    mem_addr_d  = mem_addr_q;
    mem_req_d   = mem_req_q;
    err_len_d   = adv && !redirect && !adv_ok;

    if (redirect) begin
      count_d     = 4'd0;
      head_d      = tail_q;
      head_addr_d = redirect_addr;
      fetch_d     = redirect_addr;
      if ((state_q != StIdle) && !mem_ack) begin
        // An outstanding read must finish at its old address before restarting.
        state_d = StDiscard;
      end else begin
        state_d    = StBusy;
        mem_req_d  = 1'b1;
        mem_addr_d = redirect_addr;
      end
    end else begin
      count_d = cnt_nxt;
      if (adv_ok) begin
        head_d      = wrap_add(head_q, adv_len);
        head_addr_d = head_addr_q + {28'h0000000, adv_len};
      end
      if (push) begin
        tail_d  = wrap_add(tail_q, 4'd1);
        fetch_d = fetch_q + 32'd1;
      end
      case (state_q)
        StIdle: begin
          if (cnt_nxt < QD4) begin
            state_d    = StBusy;
            mem_req_d  = 1'b1;
            mem_addr_d = fetch_q;
          end
        end
        StBusy: begin
          if (mem_ack) begin
            if (cnt_nxt < QD4) begin
              mem_addr_d = fetch_q + 32'd1;
            end else begin
              state_d   = StIdle;
              mem_req_d = 1'b0;
            end
          end
        end
        StDiscard: begin
          if (mem_ack) begin
            state_d    = StBusy;
            mem_addr_d = fetch_q;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk2 or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= 4'd0;
      head_addr_q <= RESET_ADDR;
      fetch_q     <= RESET_ADDR;
      mem_addr_q  <= RESET_ADDR;
      mem_req_q   <= 1'b0;
      err_len_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      head_addr_q <= head_addr_d;
      fetch_q     <= fetch_d;
      mem_addr_q  <= mem_addr_d;
      mem_req_q   <= mem_req_d;
      err_len_q   <= err_len_d;
    end
  end

  always_ff @(posedge clk2) begin
    if (push) buf_q[tail_q] <= mem_data;
  end

  // Bytes beyond the held count read as zero.
  always_comb begin
    ope = '0;
    for (int i = 0; i < 4; i++) begin
      if (4'(i) < count_q) ope[31-8*i -: 8] = buf_q[wrap_add(head_q, 4'(i))];
    end
  end

  assign ope_valid = (count_q >= 4'd4);
  assign head_addr = head_addr_q;
  assign count     = count_q;
  assign err_len   = err_len_q;
  assign mem_req   = mem_req_q;
  assign mem_addr  = mem_addr_q;

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: byte-queue reference model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_fetch_queue;
  localparam int unsigned QDEPTH     = 8;
  localparam logic [31:0] RESET_ADDR = 32'h0000_0000;

  logic        clk2 = 1'b0;
  logic        reset = 1'b0;
  logic        redirect;
  logic [31:0] redirect_addr;
  logic        adv;
  logic [3:0]  adv_len;
  logic [31:0] ope;
  logic        ope_valid;
  logic [31:0] head_addr;
  logic [3:0]  count;
  logic        err_len;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [7:0]  mem_data;

  always #5 clk2 = ~clk2;

  fetch_queue #(.QDEPTH(QDEPTH), .RESET_ADDR(RESET_ADDR)) dut (
    .clk2(clk2), .reset(reset), .redirect(redirect), .redirect_addr(redirect_addr),
    .adv(adv), .adv_len(adv_len), .ope(ope), .ope_valid(ope_valid), .head_addr(head_addr),
    .count(count), .err_len(err_len), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_ack(mem_ack), .mem_data(mem_data)
  );

  int checks = 0;
  int failures = 0;

  task automatic cmp(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] mem_byte(input logic [31:0] a);
    case (a)
      32'h0: return 8'h55;   32'h1: return 8'h89;   32'h2: return 8'hE5;   32'h3: return 8'hB8;
      32'h4: return 8'h2A;   32'h5: return 8'h00;   32'h6: return 8'h00;   32'h7: return 8'h00;
      32'h100: return 8'h11; 32'h101: return 8'h22; 32'h102: return 8'h33; 32'h103: return 8'h44;
      32'h104: return 8'h55; 32'h105: return 8'h66; 32'h106: return 8'h77; 32'h107: return 8'h88;
      default: return a[7:0] ^ {a[3:0], a[7:4]} ^ a[15:8] ^ a[31:24] ^ 8'h6B;
    endcase
  endfunction

  // Memory: acks after ws wait cycles on a stable request; hold suppresses acks.
  int          ws = 0;
  logic        hold = 1'b0;
  logic        ack_r = 1'b0;
  int          wcnt = 0;
  logic        last_req = 1'b0;
  logic [31:0] last_addr = '0;
  assign mem_ack = ack_r & ~hold;

  always begin
    @(posedge clk2);
    #1;
    if (reset) begin
      ack_r = 1'b0; wcnt = 0; last_req = 1'b0;
    end else begin
      if (mem_req && last_req && mem_addr == last_addr && !mem_ack) wcnt++;
      else wcnt = 0;
      last_req = mem_req;
      last_addr = mem_addr;
      ack_r = mem_req && (wcnt >= ws);
      mem_data = ack_r ? mem_byte(mem_addr) : 8'($urandom);
    end
  end

  // Reference model: a byte queue plus the single outstanding request.
  logic [7:0]  mq[$];
  logic [31:0] m_head, m_fetch, m_addr;
  bit          m_req, m_disc, m_err, m_ok, m_ack;

  always @(posedge clk2 or posedge reset) begin
    if (reset) begin
      mq.delete();
      m_head = RESET_ADDR; m_fetch = RESET_ADDR; m_addr = RESET_ADDR;
      m_req = 1'b0; m_disc = 1'b0; m_err = 1'b0;
    end else begin
      m_err = 1'b0;
      m_ack = m_req && mem_ack;
      if (redirect) begin
        mq.delete();
        m_head = redirect_addr;
        m_fetch = redirect_addr;
        if (m_req && !m_ack) m_disc = 1'b1;
        else begin m_req = 1'b1; m_disc = 1'b0; m_addr = redirect_addr; end
      end else begin
        m_ok = adv && adv_len >= 4'd1 && adv_len <= 4'd6 && int'(adv_len) <= mq.size();
        if (adv && !m_ok) m_err = 1'b1;
        if (m_ok) begin
          for (int k = 0; k < int'(adv_len); k++) void'(mq.pop_front());
          m_head = m_head + 32'(adv_len);
        end
        if (m_ack) begin
          if (m_disc) begin
            m_disc = 1'b0;
            m_addr = m_fetch;
          end else begin
            mq.push_back(mem_byte(m_fetch));
            m_fetch = m_fetch + 32'd1;
            if (mq.size() < int'(QDEPTH)) m_addr = m_fetch;
            else m_req = 1'b0;
          end
        end else if (!m_req && mq.size() < int'(QDEPTH)) begin
          m_req = 1'b1;
          m_addr = m_fetch;
        end
      end
    end
  end

  logic [31:0] exp_ope;
  always @(negedge clk2) begin
    if (!reset) begin
      exp_ope = '0;
      for (int i = 0; i < 4; i++) if (i < mq.size()) exp_ope[31-8*i -: 8] = mq[i];
      cmp("model_ope", ope, exp_ope);
      cmp("model_ope_valid", {31'b0, ope_valid}, {31'b0, mq.size() >= 4});
      cmp("model_count", {28'b0, count}, 32'(mq.size()));
      cmp("model_head_addr", head_addr, m_head);
      cmp("model_err_len", {31'b0, err_len}, {31'b0, m_err});
      cmp("model_mem_req", {31'b0, mem_req}, {31'b0, m_req});
      cmp("model_mem_addr", mem_addr, m_addr);
    end
  end

  task automatic step(input bit rd, input logic [31:0] ra, input bit a, input logic [3:0] al);
    redirect = rd; redirect_addr = ra; adv = a; adv_len = al;
    @(negedge clk2);
    redirect = 1'b0; adv = 1'b0;
  endtask

  task automatic do_reset();
    redirect = 1'b0; adv = 1'b0; hold = 1'b0;
    @(negedge clk2); #2 reset = 1'b1;
    @(negedge clk2); @(negedge clk2); #2 reset = 1'b0;
    @(negedge clk2);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1);
  end

  int n;
  bit rd, a;
  logic [31:0] ra;
  logic [3:0] al;

  initial begin
    redirect = 1'b0; redirect_addr = '0; adv = 1'b0; adv_len = '0;
    #2 reset = 1'b1;
    @(negedge clk2);
    cmp("rst_count", {28'b0, count}, 32'd0);
    cmp("rst_ope", ope, 32'h0);
    cmp("rst_ope_valid", {31'b0, ope_valid}, 32'd0);
    cmp("rst_mem_req", {31'b0, mem_req}, 32'd0);
    cmp("rst_mem_addr", mem_addr, RESET_ADDR);
    cmp("rst_head_addr", head_addr, RESET_ADDR);
    cmp("rst_err_len", {31'b0, err_len}, 32'd0);
    @(negedge clk2); #2 reset = 1'b0;
    @(negedge clk2);
    cmp("first_req", {31'b0, mem_req}, 32'd1);
    cmp("first_addr", mem_addr, 32'h0);

    // Zero-wait fill from address 0.
    n = 0;
    while (count != 4'd4 && n < 40) begin step(0, 0, 0, 0); n++; end
    cmp("fill4_ope", ope, 32'h5589E5B8);
    cmp("fill4_valid", {31'b0, ope_valid}, 32'd1);
    cmp("fill4_addr", mem_addr, 32'd4);
    n = 0;
    while (count != 4'd8 && n < 40) begin step(0, 0, 0, 0); n++; end
    cmp("full_count", {28'b0, count}, 32'd8);
    cmp("full_req_drop", {31'b0, mem_req}, 32'd0);

    // Retire one byte from the full queue.
    step(0, 0, 1, 4'd1);
    cmp("adv1_ope", ope, 32'h89E5B82A);
    cmp("adv1_head", head_addr, 32'd1);
    cmp("adv1_count", {28'b0, count}, 32'd7);
    cmp("adv1_req", {31'b0, mem_req}, 32'd1);
    cmp("adv1_addr", mem_addr, 32'd8);

    // Two-wait memory, redirect while the request for address 5 is pending.
    ws = 2;
    do_reset();
    n = 0;
    while (!(mem_req && mem_addr == 32'd5) && n < 60) begin step(0, 0, 0, 0); n++; end
    cmp("ws2_reach5", {31'b0, mem_addr == 32'd5}, 32'd1);
    step(1, 32'h40, 0, 0);
    cmp("disc_addr_hold", mem_addr, 32'd5);
    cmp("disc_req", {31'b0, mem_req}, 32'd1);
    cmp("disc_count", {28'b0, count}, 32'd0);
    cmp("disc_head", head_addr, 32'h40);
    n = 0;
    while (mem_addr == 32'd5 && n < 10) begin step(0, 0, 0, 0); n++; end
    cmp("disc_new_addr", mem_addr, 32'h40);
    cmp("disc_new_count", {28'b0, count}, 32'd0);
    cmp("disc_new_req", {31'b0, mem_req}, 32'd1);

    // Push and adv_len=2 in the same cycle at count 5.
    ws = 0;
    step(1, 32'h100, 0, 0);
    n = 0;
    while (count != 4'd5 && n < 40) begin step(0, 0, 0, 0); n++; end
    cmp("pa_reach5", {28'b0, count}, 32'd5);
    step(0, 0, 1, 4'd2);
    cmp("pa_count", {28'b0, count}, 32'd4);
    cmp("pa_head", head_addr, 32'h102);
    cmp("pa_ope", ope, 32'h33445566);

    // Illegal lengths with the memory stalled at count 3.
    step(1, 32'h100, 0, 0);
    n = 0;
    while (count != 4'd3 && n < 40) begin step(0, 0, 0, 0); n++; end
    hold = 1'b1;
    step(0, 0, 1, 4'd6);
    cmp("err6_pulse", {31'b0, err_len}, 32'd1);
    cmp("err6_count", {28'b0, count}, 32'd3);
    cmp("err6_head", head_addr, 32'h100);
    step(0, 0, 0, 0);
    cmp("err6_clear", {31'b0, err_len}, 32'd0);
    step(0, 0, 1, 4'd0);
    cmp("err0_pulse", {31'b0, err_len}, 32'd1);
    cmp("err0_count", {28'b0, count}, 32'd3);
    cmp("err0_head", head_addr, 32'h100);
    step(0, 0, 0, 0);
    cmp("err0_clear", {31'b0, err_len}, 32'd0);
    hold = 1'b0;

    // Redirect alongside adv and mem_ack.
    n = 0;
    while (!(count >= 4'd2 && mem_ack) && n < 20) begin step(0, 0, 0, 0); n++; end
    step(1, 32'h200, 1, 4'd1);
    cmp("rdadv_count", {28'b0, count}, 32'd0);
    cmp("rdadv_err", {31'b0, err_len}, 32'd0);
    cmp("rdadv_head", head_addr, 32'h200);
    cmp("rdadv_req", {31'b0, mem_req}, 32'd1);
    cmp("rdadv_addr", mem_addr, 32'h200);

    // Address wrap.
    step(1, 32'hFFFF_FFFE, 0, 0);
    cmp("wrap_a0", mem_addr, 32'hFFFF_FFFE);
    step(0, 0, 0, 0);
    cmp("wrap_a1", mem_addr, 32'hFFFF_FFFF);
    step(0, 0, 0, 0);
    cmp("wrap_a2", mem_addr, 32'h0000_0000);
    cmp("wrap_count", {28'b0, count}, 32'd2);

    // Randomized traffic.
    for (int c = 0; c < 2000; c++) begin
      if ($urandom_range(0, 99) == 0) ws = $urandom_range(0, 2);
      hold = ($urandom_range(0, 9) == 0);
      rd = ($urandom_range(0, 39) == 0);
      ra = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 + 32'($urandom_range(0, 15)) : $urandom;
      a = ($urandom_range(0, 2) == 0);
      al = ($urandom_range(0, 3) != 0) ? 4'($urandom_range(1, 4)) : 4'($urandom_range(0, 7));
      if ($urandom_range(0, 499) == 0) do_reset();
      else step(rd, ra, a, al);
    end
    hold = 1'b0;
    step(0, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
